// File: rtl/vend_pkg.sv
// Shared definitions for the item-memory arbiter: word field positions,
// vend op encoding, sequencer states and requester identifiers.
package vend_pkg;

  localparam int SOLD_MSB  = 31;
  localparam int SOLD_LSB  = 24;
  localparam int STOCK_MSB = 23;
  localparam int STOCK_LSB = 16;
  localparam int PRICE_MSB = 15;
  localparam int PRICE_LSB = 0;

  localparam logic OP_LOOKUP = 1'b0;
  localparam logic OP_VEND   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_ISSUE,
    ST_CFG_WAIT,
    ST_V_RD,
    ST_V_EVAL,
    ST_V_WR,
    ST_DONE
  } state_t;

  typedef enum logic {
    REQ_CFG  = 1'b0,
    REQ_VEND = 1'b1
  } req_id_t;

endpackage

// File: rtl/vend_rr_arb2.sv
// Two-way round-robin arbiter; the last-grant register only moves when the
// sequencer strobes a grant, so ties alternate between the requesters.
module vend_rr_arb2
  import vend_pkg::*;
(
  input  logic    clk,
  input  logic    rstn,
  input  logic    req_cfg,
  input  logic    req_vend,
  input  logic    grant_stb,
  output logic    grant_valid,
  output req_id_t grant_id
);

  req_id_t last_grant_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_reg <= REQ_VEND;
    end else if (grant_stb && grant_valid) begin
      last_grant_reg <= grant_id;
    end
  end

  always_comb begin
    grant_valid = req_cfg | req_vend;
    grant_id    = REQ_VEND;
    if (req_cfg && req_vend) begin
      grant_id = (last_grant_reg == REQ_VEND) ? REQ_CFG : REQ_VEND;
    end else if (req_cfg) begin
      grant_id = REQ_CFG;
    end
  end

endmodule

// File: rtl/vend_mem_arbiter.sv
// Arbiter/sequencer sharing a single-port item SRAM between the config agent
// and the vending FSM. Optional statistics counters: VEND_ARB_STATS_EN.
module vend_mem_arbiter
  import vend_pkg::*;
#(
  parameter int K = 64,
  parameter int D = $clog2(K)
`ifdef VEND_ARB_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         cfg_req,
  input  logic         cfg_we,
  input  logic [D-1:0] cfg_addr,
  input  logic [31:0]  cfg_wdata,
  output logic         cfg_done,
  output logic [31:0]  cfg_rdata,
  input  logic         vend_req,
  input  logic         vend_op,
  input  logic [D-1:0] vend_addr,
  output logic         vend_done,
  output logic [31:0]  vend_rdata,
  output logic         vend_ok,
  output logic         mem_en,
  output logic         mem_we,
  output logic [D-1:0] mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic [31:0]  mem_rdata,
  output logic         busy
`ifdef VEND_ARB_STATS_EN
  , output logic [CNT_W-1:0] vend_count,
  output logic [CNT_W-1:0] reject_count
`endif
);

  state_t       state_reg, state_next;
  req_id_t      gnt_reg;
  logic         we_reg;
  logic         op_reg;
  logic [D-1:0] addr_reg;
  logic [31:0]  wdata_reg;
  logic [31:0]  cfg_rdata_reg;
  logic [31:0]  vend_rdata_reg;
  logic         vend_ok_reg;

  logic         grant_valid;
  req_id_t      grant_id;
  logic         grant_stb;

  logic [7:0]   rd_stock;
  logic [7:0]   old_sold;
  logic [7:0]   sold_new;
  logic [31:0]  vend_word_new;

  assign grant_stb = (state_reg == ST_IDLE);

  vend_rr_arb2 u_arb (
    .clk         (clk),
    .rstn        (rstn),
    .req_cfg     (cfg_req),
    .req_vend    (vend_req),
    .grant_stb   (grant_stb),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign rd_stock = mem_rdata[STOCK_MSB:STOCK_LSB];
  assign old_sold = vend_rdata_reg[SOLD_MSB:SOLD_LSB];
  assign sold_new = (old_sold == 8'hFF) ? 8'hFF : old_sold + 8'd1;
  // The write-back is built from the captured pre-update word, so V_WR never
  // depends on the SRAM output that is no longer valid in that cycle.
  assign vend_word_new = {sold_new,
                          vend_rdata_reg[STOCK_MSB:STOCK_LSB] - 8'd1,
                          vend_rdata_reg[PRICE_MSB:PRICE_LSB]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= ST_IDLE;
      gnt_reg        <= REQ_CFG;
      we_reg         <= 1'b0;
      op_reg         <= OP_LOOKUP;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      cfg_rdata_reg  <= '0;
      vend_rdata_reg <= '0;
      vend_ok_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && grant_valid) begin
        gnt_reg <= grant_id;
        if (grant_id == REQ_CFG) begin
          we_reg    <= cfg_we;
          addr_reg  <= cfg_addr;
          wdata_reg <= cfg_wdata;
        end else begin
          op_reg   <= vend_op;
          addr_reg <= vend_addr;
        end
      end
      if (state_reg == ST_CFG_WAIT) begin
        cfg_rdata_reg <= mem_rdata;
      end
      if (state_reg == ST_V_EVAL) begin
        vend_rdata_reg <= mem_rdata;
        vend_ok_reg    <= (rd_stock != 8'd0);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cfg_done   = 1'b0;
    vend_done  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (grant_valid) begin
          state_next = (grant_id == REQ_CFG) ? ST_CFG_ISSUE : ST_V_RD;
        end
      end
      ST_CFG_ISSUE: begin
        mem_en     = 1'b1;
        mem_we     = we_reg;
        mem_addr   = addr_reg;
        mem_wdata  = we_reg ? wdata_reg : '0;
        state_next = we_reg ? ST_DONE : ST_CFG_WAIT;
      end
      ST_CFG_WAIT: state_next = ST_DONE;
      ST_V_RD: begin
        mem_en     = 1'b1;
        mem_addr   = addr_reg;
        state_next = ST_V_EVAL;
      end
      ST_V_EVAL: begin
        state_next = (op_reg == OP_VEND && rd_stock != 8'd0) ? ST_V_WR : ST_DONE;
      end
      ST_V_WR: begin
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = addr_reg;
        mem_wdata  = vend_word_new;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        cfg_done   = (gnt_reg == REQ_CFG);
        vend_done  = (gnt_reg == REQ_VEND);
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy       = (state_reg != ST_IDLE);
  assign cfg_rdata  = cfg_rdata_reg;
  assign vend_rdata = vend_rdata_reg;
  assign vend_ok    = vend_ok_reg;

`ifdef VEND_ARB_STATS_EN
  logic [CNT_W-1:0] vend_count_reg;
  logic [CNT_W-1:0] reject_count_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vend_count_reg   <= '0;
      reject_count_reg <= '0;
    end else begin
      if (state_reg == ST_V_WR && vend_count_reg != '1) begin
        vend_count_reg <= vend_count_reg + 1'b1;
      end
      if (state_reg == ST_V_EVAL && op_reg == OP_VEND && rd_stock == 8'd0 &&
          reject_count_reg != '1) begin
        reject_count_reg <= reject_count_reg + 1'b1;
      end
    end
  end

  assign vend_count   = vend_count_reg;
  assign reject_count = reject_count_reg;
`endif

endmodule

// File: tb/tb_vend_mem_arbiter.sv
// Self-checking bench for vend_mem_arbiter: directed scenarios plus randomized
// traffic checked against a word-level model of the item memory.
module tb_vend_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_req, cfg_we;
  logic [5:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_done;
  logic [31:0] cfg_rdata;
  logic        vend_req, vend_op;
  logic [5:0]  vend_addr;
  logic        vend_done;
  logic [31:0] vend_rdata;
  logic        vend_ok;
  logic        mem_en, mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
`ifdef VEND_ARB_STATS_EN
  logic [15:0] vend_count, reject_count;
`endif

  always #5 clk = ~clk;

  vend_mem_arbiter dut (
    .clk(clk), .rstn(rstn),
    .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_done(cfg_done), .cfg_rdata(cfg_rdata),
    .vend_req(vend_req), .vend_op(vend_op), .vend_addr(vend_addr),
    .vend_done(vend_done), .vend_rdata(vend_rdata), .vend_ok(vend_ok),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
`ifdef VEND_ARB_STATS_EN
    , .vend_count(vend_count), .reject_count(reject_count)
`endif
  );

  // Synchronous single-port SRAM, one cycle read latency
  logic [31:0] sram [0:63];
  logic [31:0] sram_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        sram_q <= sram[mem_addr];
    end
  end
  assign mem_rdata = sram_q;

  // Reference model state
  logic [31:0] ref_mem [0:63];
  bit          model_last;   // 1 = vend was granted last
  int          model_vcnt, model_rcnt;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic bit model_ok(input logic [31:0] w);
    return w[23:16] != 8'd0;
  endfunction

  function automatic logic [31:0] model_after_vend(input logic [31:0] w);
    int sold, stock;
    sold  = w[31:24];
    stock = w[23:16];
    sold  = (sold < 255) ? sold + 1 : 255;
    stock = stock - 1;
    return {sold[7:0], stock[7:0], w[15:0]};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [7:0] s, st;
    s  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
    case ($urandom_range(0, 3))
      0:       st = 8'd0;
      1:       st = 8'd1;
      default: st = 8'($urandom_range(0, 255));
    endcase
    return {s, st, 16'($urandom)};
  endfunction

  task automatic apply_reset();
    rstn = 1'b0; cfg_req = 0; vend_req = 0; cfg_we = 0; vend_op = 0;
    cfg_addr = 0; vend_addr = 0; cfg_wdata = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_last = 1'b1; model_vcnt = 0; model_rcnt = 0;
  endtask

  // Drives one transaction from a single requester and records what happened
  task automatic run_single(input bit is_cfg, input bit wop, input logic [5:0] a,
                            input logic [31:0] wd, output int done_cyc, output int we_cyc,
                            output logic [31:0] we_data, output logic [5:0] we_addr,
                            output int n_we, output int busy_cyc,
                            output logic [31:0] rd, output logic ok);
    done_cyc = -1; we_cyc = -1; we_data = 'x; we_addr = 'x; n_we = 0; busy_cyc = 0;
    rd = 'x; ok = 1'bx;
    @(negedge clk);
    if (is_cfg) begin cfg_req = 1; cfg_we = wop; cfg_addr = a; cfg_wdata = wd; end
    else begin vend_req = 1; vend_op = wop; vend_addr = a; end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_en && mem_we) begin n_we++; we_cyc = c; we_data = mem_wdata; we_addr = mem_addr; end
      if (busy) busy_cyc++;
      if (is_cfg ? cfg_done : vend_done) begin
        done_cyc = c; rd = is_cfg ? cfg_rdata : vend_rdata; ok = vend_ok;
        break;
      end
    end
    cfg_req = 0; vend_req = 0;
  endtask

  // Both requesters assert together; each drops when its own done appears
  task automatic run_dual(input bit cwe, input logic [5:0] ca, input logic [31:0] cwd,
                          input bit vop, input logic [5:0] va,
                          output int cdone, output int vdone, output logic [31:0] crd,
                          output logic [31:0] vrd, output logic vok, output int n_we,
                          output bit first_vend);
    bit seen;
    cdone = -1; vdone = -1; crd = 'x; vrd = 'x; vok = 1'bx; n_we = 0; first_vend = 0; seen = 0;
    @(negedge clk);
    cfg_req = 1; cfg_we = cwe; cfg_addr = ca; cfg_wdata = cwd;
    vend_req = 1; vend_op = vop; vend_addr = va;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (mem_en && mem_we) n_we++;
      if (cfg_done) begin
        cdone = c; crd = cfg_rdata; cfg_req = 0;
        if (!seen) begin seen = 1; first_vend = 0; end
      end
      if (vend_done) begin
        vdone = c; vrd = vend_rdata; vok = vend_ok; vend_req = 0;
        if (!seen) begin seen = 1; first_vend = 1; end
      end
      if (cdone > 0 && vdone > 0) break;
    end
    cfg_req = 0; vend_req = 0;
  endtask

  logic [107:0] out_vec;
  assign out_vec = {cfg_done, vend_done, cfg_rdata, vend_rdata, vend_ok,
                    mem_en, mem_we, mem_addr, mem_wdata, busy};

  int dc, wc, nw, bc;
  logic [31:0] wdat, rd;
  logic [5:0]  wadr;
  logic        ok;

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    vectors++;
    if (out_vec !== '0) begin miscompares++; $display("FAIL reset_outputs got=%h exp=0", out_vec); end
  endtask

  task automatic test_cfg_write();
    run_single(1, 1, 6'd5, 32'h000A0032, dc, wc, wdat, wadr, nw, bc, rd, ok);
    ref_mem[5] = 32'h000A0032;
    vectors++; if (dc !== 2) begin miscompares++; $display("FAIL cfg_wr_done_cycle got=%0d exp=2", dc); end
    vectors++; if (wc !== 1 || nw !== 1) begin miscompares++; $display("FAIL cfg_wr_we_cycle got=%0d/%0d exp=1/1", wc, nw); end
    vectors++; if (wadr !== 6'd5 || wdat !== 32'h000A0032) begin miscompares++; $display("FAIL cfg_wr_mem got=%0d:%h exp=5:000a0032", wadr, wdat); end
    vectors++; if (bc !== 2) begin miscompares++; $display("FAIL cfg_wr_busy_cycles got=%0d exp=2", bc); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL cfg_wr_busy_in_done got=%b exp=1", busy); end
  endtask

  task automatic test_cfg_read();
    run_single(1, 0, 6'd5, 32'h0, dc, wc, wdat, wadr, nw, bc, rd, ok);
    vectors++; if (dc !== 3) begin miscompares++; $display("FAIL cfg_rd_done_cycle got=%0d exp=3", dc); end
    vectors++; if (rd !== ref_mem[5]) begin miscompares++; $display("FAIL cfg_rd_data got=%h exp=%h", rd, ref_mem[5]); end
    vectors++; if (nw !== 0) begin miscompares++; $display("FAIL cfg_rd_no_write got=%0d exp=0", nw); end
  endtask

  task automatic test_vend();
    run_single(0, 1, 6'd5, 32'h0, dc, wc, wdat, wadr, nw, bc, rd, ok);
    vectors++; if (wc !== 3 || wdat !== 32'h01090032) begin miscompares++; $display("FAIL vend_write got=c%0d:%h exp=c3:01090032", wc, wdat); end
    vectors++; if (dc !== 4) begin miscompares++; $display("FAIL vend_done_cycle got=%0d exp=4", dc); end
    vectors++; if (ok !== 1'b1 || rd !== 32'h000A0032) begin miscompares++; $display("FAIL vend_result got=%b:%h exp=1:000a0032", ok, rd); end
    ref_mem[5] = model_after_vend(ref_mem[5]);
    model_vcnt++;
  endtask

  task automatic test_vend_empty();
    run_single(1, 1, 6'd7, 32'h05000032, dc, wc, wdat, wadr, nw, bc, rd, ok);
    ref_mem[7] = 32'h05000032;
    run_single(0, 1, 6'd7, 32'h0, dc, wc, wdat, wadr, nw, bc, rd, ok);
    model_rcnt++;
    vectors++; if (nw !== 0) begin miscompares++; $display("FAIL empty_no_write got=%0d exp=0", nw); end
    vectors++; if (dc !== 3 || ok !== 1'b0) begin miscompares++; $display("FAIL empty_done got=c%0d ok=%b exp=c3 ok=0", dc, ok); end
`ifdef VEND_ARB_STATS_EN
    vectors++; if (reject_count !== 16'd1) begin miscompares++; $display("FAIL empty_reject_count got=%0d exp=1", reject_count); end
`endif
  endtask

  task automatic test_saturate();
    run_single(1, 1, 6'd9, 32'hFF030032, dc, wc, wdat, wadr, nw, bc, rd, ok);
    ref_mem[9] = 32'hFF030032;
    run_single(0, 1, 6'd9, 32'h0, dc, wc, wdat, wadr, nw, bc, rd, ok);
    ref_mem[9] = model_after_vend(ref_mem[9]);
    model_vcnt++;
    vectors++; if (wdat !== 32'hFF020032 || wadr !== 6'd9) begin miscompares++; $display("FAIL sat_write got=%0d:%h exp=9:ff020032", wadr, wdat); end
    // A LOOKUP never writes even with stock available
    run_single(0, 0, 6'd5, 32'h0, dc, wc, wdat, wadr, nw, bc, rd, ok);
    vectors++; if (nw !== 0 || dc !== 3 || ok !== 1'b1 || rd !== ref_mem[5]) begin
      miscompares++; $display("FAIL lookup got=w%0d c%0d ok=%b %h exp=w0 c3 ok=1 %h", nw, dc, ok, rd, ref_mem[5]);
    end
`ifdef VEND_ARB_STATS_EN
    vectors++; if (vend_count !== 16'(model_vcnt)) begin miscompares++; $display("FAIL vend_count got=%0d exp=%0d", vend_count, model_vcnt); end
`endif
  endtask

  task automatic test_reset_mid();
    int writes;
    run_single(1, 1, 6'd11, 32'h00040010, dc, wc, wdat, wadr, nw, bc, rd, ok);
    ref_mem[11] = 32'h00040010;
    writes = 0;
    @(negedge clk);
    vend_req = 1; vend_op = 1; vend_addr = 6'd11;
    @(negedge clk);                 // V_RD
    @(negedge clk);                 // V_EVAL
    rstn = 1'b0;
    #1;
    vectors++; if (out_vec !== '0) begin miscompares++; $display("FAIL mid_reset_outputs got=%h exp=0", out_vec); end
    vend_req = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_we) writes++;
    end
    rstn = 1'b1;
    model_last = 1'b1; model_vcnt = 0; model_rcnt = 0;
    run_single(1, 0, 6'd11, 32'h0, dc, wc, wdat, wadr, nw, bc, rd, ok);
    vectors++; if (writes !== 0 || rd !== 32'h00040010) begin miscompares++; $display("FAIL mid_reset_mem got=w%0d %h exp=w0 00040010", writes, rd); end
    model_last = 1'b0;
  endtask

  task automatic test_arbitration();
    int cd, vd; logic [31:0] crd, vrd; logic vok; bit fv;
    apply_reset();
    // cfg writes addr 20, vend looks it up afterwards
    run_dual(1, 6'd20, 32'h00070100, 0, 6'd20, cd, vd, crd, vrd, vok, nw, fv);
    ref_mem[20] = 32'h00070100;
    vectors++; if (fv !== 1'b0 || cd !== 2 || vd !== 6) begin miscompares++; $display("FAIL arb_first got=v%b c%0d/%0d exp=v0 c2/6", fv, cd, vd); end
    vectors++; if (vrd !== 32'h00070100 || vok !== 1'b1) begin miscompares++; $display("FAIL arb_lookup got=%h ok=%b exp=00070100 ok=1", vrd, vok); end
    run_dual(0, 6'd20, 32'h0, 1, 6'd20, cd, vd, crd, vrd, vok, nw, fv);
    ref_mem[20] = model_after_vend(ref_mem[20]);
    model_vcnt++;
    vectors++; if (fv !== 1'b0 || crd !== 32'h00070100) begin miscompares++; $display("FAIL arb_second got=v%b %h exp=v0 00070100", fv, crd); end
    model_last = 1'b1;
  endtask

  task automatic test_random();
    for (int a = 0; a < 16; a++) begin
      logic [31:0] w;
      w = rand_word();
      run_single(1, 1, 6'(a), w, dc, wc, wdat, wadr, nw, bc, rd, ok);
      ref_mem[a] = w;
      model_last = 1'b0;
      vectors++; if (sram[a] !== w) begin miscompares++; $display("FAIL rnd_fill[%0d] got=%h exp=%h", a, sram[a], w); end
    end
    for (int it = 0; it < 60; it++) begin
      int kind;
      bit cwe, vop;
      logic [5:0] ca, va;
      logic [31:0] cwd, vword, cword_seen;
      int lat_c, lat_v, exp_we;
      kind = $urandom_range(0, 2);
      cwe = 1'($urandom); vop = ($urandom_range(0, 3) != 0);
      ca = 6'($urandom_range(0, 15)); va = 6'($urandom_range(0, 15));
      cwd = rand_word();
      if (kind == 0) begin
        run_single(1, cwe, ca, cwd, dc, wc, wdat, wadr, nw, bc, rd, ok);
        model_last = 1'b0;
        vectors++;
        if (cwe) begin
          if (dc !== 2 || nw !== 1 || wdat !== cwd || wadr !== ca) begin miscompares++; $display("FAIL rnd%0d cfg_wr got=c%0d w%0d %0d:%h exp=c2 w1 %0d:%h", it, dc, nw, wadr, wdat, ca, cwd); end
          ref_mem[ca] = cwd;
        end else if (dc !== 3 || nw !== 0 || rd !== ref_mem[ca]) begin
          miscompares++; $display("FAIL rnd%0d cfg_rd got=c%0d w%0d %h exp=c3 w0 %h", it, dc, nw, rd, ref_mem[ca]);
        end
      end else if (kind == 1) begin
        run_single(0, vop, va, 32'h0, dc, wc, wdat, wadr, nw, bc, rd, ok);
        model_last = 1'b1;
        vword = ref_mem[va];
        exp_we = (vop && model_ok(vword)) ? 1 : 0;
        vectors++;
        if (dc !== 3 + exp_we || nw !== exp_we || rd !== vword || ok !== model_ok(vword) ||
            (exp_we == 1 && (wdat !== model_after_vend(vword) || wadr !== va))) begin
          miscompares++;
          $display("FAIL rnd%0d vend got=c%0d w%0d ok=%b %h wr=%h exp=c%0d w%0d ok=%b %h wr=%h", it, dc, nw, ok, rd, wdat,
                   3 + exp_we, exp_we, model_ok(vword), vword, model_after_vend(vword));
        end
        if (vop && model_ok(vword)) begin ref_mem[va] = model_after_vend(vword); model_vcnt++; end
        else if (vop) model_rcnt++;
      end else begin
        int cd, vd; logic [31:0] crd, vrd; logic vok; bit fv, exp_fv;
        run_dual(cwe, ca, cwd, vop, va, cd, vd, crd, vrd, vok, nw, fv);
        exp_fv = !model_last;
        if (!exp_fv) begin
          cword_seen = ref_mem[ca];
          if (cwe) ref_mem[ca] = cwd;
        end
        vword = ref_mem[va];
        exp_we = (vop && model_ok(vword)) ? 1 : 0;
        if (vop && model_ok(vword)) begin ref_mem[va] = model_after_vend(vword); model_vcnt++; end
        else if (vop) model_rcnt++;
        if (exp_fv) begin
          cword_seen = ref_mem[ca];
          if (cwe) ref_mem[ca] = cwd;
        end
        lat_c = cwe ? 2 : 3;
        lat_v = 3 + exp_we;
        model_last = exp_fv ? 1'b0 : 1'b1;
        vectors++;
        if (fv !== exp_fv || nw !== exp_we + (cwe ? 1 : 0) ||
            cd !== (exp_fv ? lat_v + 1 + lat_c : lat_c) || vd !== (exp_fv ? lat_v : lat_c + 1 + lat_v) ||
            vrd !== vword || vok !== model_ok(vword) || (!cwe && crd !== cword_seen)) begin
          miscompares++;
          $display("FAIL rnd%0d dual got=v%b w%0d c%0d/%0d %h %h exp=v%b w%0d %h %h", it, fv, nw, cd, vd, crd, vrd,
                   exp_fv, exp_we + (cwe ? 1 : 0), cword_seen, vword);
        end
      end
    end
    for (int a = 0; a < 16; a++) begin
      vectors++; if (sram[a] !== ref_mem[a]) begin miscompares++; $display("FAIL rnd_final[%0d] got=%h exp=%h", a, sram[a], ref_mem[a]); end
    end
`ifdef VEND_ARB_STATS_EN
    vectors++; if (vend_count !== 16'(model_vcnt) || reject_count !== 16'(model_rcnt)) begin
      miscompares++; $display("FAIL rnd_stats got=%0d/%0d exp=%0d/%0d", vend_count, reject_count, model_vcnt, model_rcnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_cfg_write();
    test_cfg_read();
    test_vend();
    test_vend_empty();
    test_saturate();
    test_reset_mid();
    test_arbitration();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
